alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised successor of the datapath's 64-bit ALU.
- Adds a valid/ready handshake on both input and output, a registered result with backpressure, signed-overflow and set-less-than support, and barrel shifts.
- Adds an iterative shift-add multiplier that runs as a multi-cycle operation under a small FSM.
- Sits between the register-file read stage and writeback; the execute stage stalls on in_ready/out_valid.

Parameters:
- WIDTH, 64, operand/result width in bits; must be >= 4 and a power of two.
- MUL_EN, 1, 1 = multiply opcode implemented; 0 = opcode 1000 treated as undefined.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operands and opcode presented.
- in_ready  output  1  block can accept; transfer occurs when in_valid && in_ready at a rising edge.
- read_data_1  input  WIDTH  operand A.
- read_data_2  input  WIDTH  operand B; shift amount is its low log2(WIDTH) bits.
- ALUcontrol  input  4  opcode.
- out_valid  output  1  result registers hold a valid result.
- out_ready  input  1  consumer accepts the result when out_valid && out_ready.
- ALUresult  output  WIDTH  registered result.
- zero  output  1  ALUresult == 0.
- overflow  output  1  signed overflow; defined for ADD/SUB only, 0 otherwise.
- busy  output  1  multiply in progress.

Behaviour:
- Opcodes:
  - 0000 AND.
  - 0001 OR.
  - 0010 ADD.
  - 0110 SUB (A-B).
  - 0111 SLT: result 1 if A<B signed, else 0.
  - 1100 NOR.
  - 0011 SLL.
  - 0100 SRL.
  - 0101 SRA (arithmetic).
  - 1000 MUL: low WIDTH bits of A*B; the value is the same whether operands are treated as signed or unsigned.
  - Any other opcode, or 1000 with MUL_EN=0: result 0, zero=1, overflow=0, latency 1.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH. Overflow = operand sign bits agree (ADD) or differ (SUB) and the result sign differs from A's sign.
- FSM states:
  - IDLE: no multiply in progress.
  - MUL: iterating.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !rst.
- Single-cycle ops (IDLE, accept at edge T):
  - ALUresult, zero and overflow are loaded at edge T.
  - out_valid is 1 after edge T (latency 1).
  - Back-to-back accepts are allowed while the consumer drains every cycle, giving 1 op/cycle throughput.
- MUL (accept at edge T):
  - Latches A, B and clears the accumulator.
  - Goes to MUL with an iteration counter = WIDTH; busy=1.
  - Each edge: if the multiplier LSB is 1, add the multiplicand; then multiplicand <<1, multiplier >>1, counter-1.
  - On the edge where the counter reaches 0: load ALUresult/zero, overflow=0, out_valid=1, state returns to IDLE, busy=0.
  - out_valid rises after edge T+WIDTH.
  - in_ready=0 throughout MUL.
  - A pending unconsumed previous result already blocks acceptance, so MUL never overwrites an undrained result.
- Output hold:
  - While out_valid && !out_ready, ALUresult/zero/overflow are stable.
  - On a drain with no new accept, out_valid goes to 0 and ALUresult keeps its last value.
  - Drain and new single-cycle accept on the same edge: out_valid stays 1 with the new result.
- Reset (any time, including mid-MUL): immediately state=IDLE, counter=0, out_valid=0, ALUresult=0, zero=1, overflow=0, busy=0, in_ready=0. The multiply in progress is discarded, with no partial result. in_ready=1 in the first cycle after deassertion.
- Inputs are ignored when in_valid=0 or in_ready=0. Operand changes during MUL have no effect.

Test Plan:
- WIDTH=64, ADD 0x7FFF_FFFF_FFFF_FFFF + 1, out_ready=1 -> next cycle out_valid=1, ALUresult=0x8000_0000_0000_0000, overflow=1, zero=0.
- SUB 5-5 then SLT -1 vs 1 on consecutive cycles, out_ready=1 -> results 0 (zero=1) then 1, one per cycle, in_ready never drops.
- WIDTH=8: SRA 0x80 by 3 -> 0xF0; SLL 0x81 by 1 -> 0x02; SRL 0x80 by 7 -> 0x01.
- WIDTH=8 MUL 13*11 -> busy=1 and in_ready=0 for 8 cycles; out_valid after edge T+8 with ALUresult=0x8F. MUL 0xFF*0xFF -> 0x01.
- Backpressure: hold out_ready=0 after an AND 0xF0&0x3C -> 0x30 held stable for 5 cycles and in_ready=0; raise out_ready -> drains, in_ready=1.
- Assert rst at MUL iteration 4 -> out_valid=0, ALUresult=0, zero=1, busy=0 immediately; after release a new ADD 2+3 returns 5 at latency 1.

Source files
------------

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with registered result and iterative shift-add multiplier
module alu_seq #(
  parameter int WIDTH  = 64,
  parameter bit MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] read_data_1,
  input  logic [WIDTH-1:0] read_data_2,
  input  logic [3:0]       ALUcontrol,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUresult,
  output logic             zero,
  output logic             overflow,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_nxt;
  logic [WIDTH-1:0] res_c, sum, diff;
  logic             ovf_c, is_mul, accept, mul_done;
  logic [SW-1:0]    sh;

  assign in_ready = (state == S_IDLE) && (!out_valid || out_ready) && !rst;
  assign accept   = in_valid && in_ready;
  assign is_mul   = MUL_EN && (ALUcontrol == OP_MUL);
  assign mul_done = (state == S_MUL) && (cnt == CW'(1));
  assign busy     = (state == S_MUL);
  assign acc_nxt  = acc + (mplier[0] ? mcand : '0);
  assign sh       = read_data_2[SW-1:0];
  assign sum      = read_data_1 + read_data_2;
  assign diff     = read_data_1 - read_data_2;

  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    case (ALUcontrol)
      OP_AND: res_c = read_data_1 & read_data_2;
      OP_OR:  res_c = read_data_1 | read_data_2;
      OP_NOR: res_c = ~(read_data_1 | read_data_2);
      OP_ADD: begin
        res_c = sum;
        ovf_c = (read_data_1[WIDTH-1] == read_data_2[WIDTH-1]) &&
                (sum[WIDTH-1] != read_data_1[WIDTH-1]);
      end
      OP_SUB: begin
        res_c = diff;
        ovf_c = (read_data_1[WIDTH-1] != read_data_2[WIDTH-1]) &&
                (diff[WIDTH-1] != read_data_1[WIDTH-1]);
      end
      OP_SLT: res_c = {{(WIDTH-1){1'b0}}, ($signed(read_data_1) < $signed(read_data_2))};
      OP_SLL: res_c = read_data_1 << sh;
      OP_SRL: res_c = read_data_1 >> sh;
      OP_SRA: res_c = $signed(read_data_1) >>> sh;
      default: begin
        res_c = '0;
        ovf_c = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept && is_mul) state_nxt = S_MUL;
      S_MUL:  if (mul_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Multiplier datapath: one shift-add step per cycle while in S_MUL
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (accept && is_mul) begin
      mcand  <= read_data_1;
      mplier <= read_data_2;
      acc    <= '0;
      cnt    <= CNT_INIT;
    end else if (state == S_MUL) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

  // Result registers only change on a new result; a drain just drops out_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      ALUresult <= '0;
      zero      <= 1'b1;
      overflow  <= 1'b0;
    end else if (accept && !is_mul) begin
      out_valid <= 1'b1;
      ALUresult <= res_c;
      zero      <= (res_c == '0);
      overflow  <= ovf_c;
    end else if (mul_done) begin
      out_valid <= 1'b1;
      ALUresult <= acc_nxt;
      zero      <= (acc_nxt == '0);
      overflow  <= 1'b0;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
